// File: rtl/kypd_pkg.sv
// Shared definitions for the PmodKYPD scanner.
//   key_code_e : 4-bit key codes KEY_0..KEY_F
//   key_t      : {valid, code} key state; KEY_NONE = no key closed
//   col_drive  : column index -> active-low one-hot column drive pattern
//   key_map    : (column, row) -> key code for the 4x4 PmodKYPD layout
//   first_row  : lowest-numbered closed row of an active-low row vector
package kypd_pkg;

   typedef enum logic [3:0] {
      KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
      KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
      KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
      KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF
   } key_code_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } key_t;

   localparam key_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

   localparam logic [3:0] COL_DRV_0 = 4'b0111;
   localparam logic [3:0] COL_DRV_1 = 4'b1011;
   localparam logic [3:0] COL_DRV_2 = 4'b1101;
   localparam logic [3:0] COL_DRV_3 = 4'b1110;

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      logic [3:0] drv;
      case (c)
         2'd0:    drv = COL_DRV_0;
         2'd1:    drv = COL_DRV_1;
         2'd2:    drv = COL_DRV_2;
         default: drv = COL_DRV_3;
      endcase
      return drv;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
      key_code_e k;
      case ({c, r})
         4'b00_00: k = KEY_1;
         4'b00_01: k = KEY_4;
         4'b00_10: k = KEY_7;
         4'b00_11: k = KEY_0;
         4'b01_00: k = KEY_2;
         4'b01_01: k = KEY_5;
         4'b01_10: k = KEY_8;
         4'b01_11: k = KEY_F;
         4'b10_00: k = KEY_3;
         4'b10_01: k = KEY_6;
         4'b10_10: k = KEY_9;
         4'b10_11: k = KEY_E;
         4'b11_00: k = KEY_A;
         4'b11_01: k = KEY_B;
         4'b11_10: k = KEY_C;
         default:  k = KEY_D;
      endcase
      return k;
   endfunction

   // Row 0 has priority; with no row closed the result is don't-care (3).
   function automatic logic [1:0] first_row(input logic [3:0] row_n);
      logic [1:0] r;
      if (!row_n[0])      r = 2'd0;
      else if (!row_n[1]) r = 2'd1;
      else if (!row_n[2]) r = 2'd2;
      else                r = 2'd3;
      return r;
   endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Frame-rate debouncer for the scanned key state.
//   clk, reset     : clock, asynchronous active-low reset
//   frame_end_i    : one-cycle pulse when a complete scan frame result is on raw_i
//   raw_i          : {valid, code} result of the frame (KEY_NONE if nothing closed)
//   accept_o       : pulses in the frame_end cycle when the accepted state changes
//   accepted_nxt_o : accepted state including this cycle's update (for registering)
module kypd_debounce
   import kypd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_COUNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_end_i,
   input  key_t raw_i,
   output logic accept_o,
   output key_t accepted_nxt_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT);

   key_t             cand_q, cand_d;
   key_t             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept_d;

   // The count only reaches CNT_MAX right after a run of identical frames, and
   // acceptance immediately equalises acc and cand, so testing cand != acc when
   // the count is at CNT_MAX fires exactly once per stable new state.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      accept_d = 1'b0;
      if (frame_end_i) begin
         if (raw_i == cand_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cand_d = raw_i;
            cnt_d  = CNT_W'(1);
         end
         if (cnt_d == CNT_MAX && cand_d != acc_q) begin
            acc_d    = cand_d;
            accept_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand_q <= KEY_NONE;
         cnt_q  <= '0;
         acc_q  <= KEY_NONE;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end

   assign accept_o       = accept_d;
   assign accepted_nxt_o = acc_d;

endmodule

// File: rtl/kypd_scanner.sv
// PmodKYPD 4x4 keypad scanner feeding music_player.
//   clk            : system clock
//   reset          : asynchronous active-low reset
//   row[3:0]       : row returns, active-low
//   col[3:0]       : column drive, active-low one-hot (col 0 = 4'b0111)
//   instruments    : code of the last accepted key press, held between presses
//   new_instrument : one-cycle strobe coincident with an instruments update
//   key_down       : high while the debounced state is a pressed key
module kypd_scanner
   import kypd_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES    = 100000,
   parameter int unsigned DEBOUNCE_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] instruments,
   output logic       new_instrument,
   output logic       key_down
);

   localparam int unsigned SLOT_W = $clog2(SCAN_CYCLES);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);

   logic [3:0]        row_s1_q, row_s1_d;
   logic [3:0]        row_s2_q, row_s2_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [3:0]        col_q, col_d;
   key_t              frame_hit_q, frame_hit_d;
   logic [3:0]        instruments_q, instruments_d;
   logic              new_instrument_q, new_instrument_d;
   logic              key_down_q, key_down_d;

   logic capture;
   logic frame_end;
   logic col_hit;
   key_t col_key;
   key_t raw;
   logic accept;
   key_t accepted_nxt;

   // Scan timing, per-frame key priority and output update.
   always_comb begin
      row_s1_d = row;
      row_s2_d = row_s1_q;

      capture   = (slot_q == SLOT_LAST);
      frame_end = capture && (col_idx_q == 2'd3);

      slot_d    = capture ? '0 : slot_q + SLOT_W'(1);
      col_idx_d = capture ? col_idx_q + 2'd1 : col_idx_q;
      col_d     = col_drive(col_idx_d);

      col_hit       = ~&row_s2_q;
      col_key.valid = 1'b1;
      col_key.code  = key_map(col_idx_q, first_row(row_s2_q));

      // Earlier columns win, so a hit already held for this frame is kept.
      if (frame_hit_q.valid) raw = frame_hit_q;
      else if (col_hit)      raw = col_key;
      else                   raw = KEY_NONE;

      frame_hit_d = frame_hit_q;
      if (capture) begin
         if (frame_end) frame_hit_d = KEY_NONE;
         else           frame_hit_d = raw;
      end

      new_instrument_d = accept && accepted_nxt.valid;
      instruments_d    = new_instrument_d ? accepted_nxt.code : instruments_q;
      key_down_d       = accepted_nxt.valid;
   end

   kypd_debounce #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_debounce (
      .clk           (clk),
      .reset         (reset),
      .frame_end_i   (frame_end),
      .raw_i         (raw),
      .accept_o      (accept),
      .accepted_nxt_o(accepted_nxt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_s1_q         <= '1;
         row_s2_q         <= '1;
         slot_q           <= '0;
         col_idx_q        <= '0;
         col_q            <= COL_DRV_0;
         frame_hit_q      <= KEY_NONE;
         instruments_q    <= '0;
         new_instrument_q <= 1'b0;
         key_down_q       <= 1'b0;
      end else begin
         row_s1_q         <= row_s1_d;
         row_s2_q         <= row_s2_d;
         slot_q           <= slot_d;
         col_idx_q        <= col_idx_d;
         col_q            <= col_d;
         frame_hit_q      <= frame_hit_d;
         instruments_q    <= instruments_d;
         new_instrument_q <= new_instrument_d;
         key_down_q       <= key_down_d;
      end
   end

   assign col            = col_q;
   assign instruments    = instruments_q;
   assign new_instrument = new_instrument_q;
   assign key_down       = key_down_q;

endmodule

// File: tb/tb_kypd_scanner.sv
// Self-checking bench for kypd_scanner with SCAN_CYCLES=8, DEBOUNCE_COUNT=3
// (one frame = 32 clocks). Stimulus pushes expected key codes; a monitor pops
// one entry per new_instrument strobe.
module tb_kypd_scanner;

   localparam int FRAME = 32;

   // Key positions as bit index c*4+r into pressed.
   localparam int K_2 = 4;   // c1 r0
   localparam int K_5 = 5;   // c1 r1
   localparam int K_9 = 10;  // c2 r2
   localparam int K_E = 11;  // c2 r3
   localparam int K_A = 12;  // c3 r0
   localparam int K_D = 15;  // c3 r3

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] instruments;
   logic       new_instrument;
   logic       key_down;

   logic [15:0] pressed = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;
   longint      cyc = 0;
   longint      min_strobe_cyc = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  mon_exp;
   logic        prev_strobe = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   kypd_scanner #(
      .SCAN_CYCLES(8),
      .DEBOUNCE_COUNT(3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .row           (row),
      .col           (col),
      .instruments   (instruments),
      .new_instrument(new_instrument),
      .key_down      (key_down)
   );

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] p;
      case (c)
         0:       p = 4'b0111;
         1:       p = 4'b1011;
         2:       p = 4'b1101;
         default: p = 4'b1110;
      endcase
      return p;
   endfunction

   // Keypad: a closed switch pulls its row low only while its column is driven.
   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         if (col == col_pat(c)) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[c*4 + r]) row[r] = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (prev_strobe) begin
         checks++;
         if (new_instrument !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: new_instrument=%b on cycle after strobe, required 0", new_instrument);
         end
      end
      if (new_instrument === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: instruments=%h, required no strobe", instruments);
         end else begin
            mon_exp = exp_q.pop_front();
            checks++;
            if (instruments !== mon_exp) begin
               errors++;
               $display("FAIL strobe_code: instruments=%h, required %h", instruments, mon_exp);
            end
            checks++;
            if (key_down !== 1'b1) begin
               errors++;
               $display("FAIL strobe_key_down: key_down=%b, required 1", key_down);
            end
            if (min_strobe_cyc != 0) begin
               checks++;
               if (cyc < min_strobe_cyc) begin
                  errors++;
                  $display("FAIL strobe_too_early: cycle=%0d, required >= %0d", cyc, min_strobe_cyc);
               end
               min_strobe_cyc = 0;
            end
         end
      end
      prev_strobe = new_instrument;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic press_only(input int k);
      pressed = '0;
      if (k >= 0) pressed[k] = 1'b1;
   endtask

   task automatic hold_frames(input int n);
      repeat (n * FRAME) @(posedge clk);
      #1;
   endtask

   // Returns 1 time unit after the clock edge on which column 0 starts driving.
   task automatic align_frame();
      logic [3:0]  prev;
      int unsigned n;
      prev = col;
      n = 0;
      while (n < 64) begin
         @(posedge clk);
         #1;
         if (prev == 4'b1110 && col == 4'b0111) break;
         prev = col;
         n++;
      end
      checks++;
      if (n >= 64) begin
         errors++;
         $display("FAIL align_frame: no frame start within %0d cycles, required one", n);
      end
   endtask

   int bounce_pat[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};

   initial begin
      // Reset state
      #12;
      chk("reset_col", col, 4'b0111);
      chk("reset_instruments", instruments, 4'h0);
      chk("reset_new_instrument", new_instrument, 1'b0);
      chk("reset_key_down", key_down, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      chk("col_slot7", col, 4'b0111);
      @(posedge clk);
      #1;
      chk("col_after_8", col, 4'b1011);

      // Hold '5' for 20 frames: one strobe within the first 4 frames
      align_frame();
      press_only(K_5);
      exp_q.push_back(4'h5);
      hold_frames(4);
      chk("strobe_5_seen", exp_q.size(), 0);
      hold_frames(16);
      chk("key_down_5", key_down, 1'b1);

      // Release for one frame only: no new strobe
      press_only(-1);
      hold_frames(1);
      press_only(K_5);
      hold_frames(5);
      chk("key_down_short_release", key_down, 1'b1);

      // Release for 4 frames: "none" accepted, re-press strobes again
      press_only(-1);
      hold_frames(4);
      chk("key_down_released", key_down, 1'b0);
      press_only(K_5);
      exp_q.push_back(4'h5);
      hold_frames(4);
      chk("strobe_5_repress_seen", exp_q.size(), 0);
      press_only(-1);
      hold_frames(4);
      chk("key_down_released_2", key_down, 1'b0);

      // '9' bouncing in half-frame steps, never 3 identical frames
      for (int i = 0; i < 10; i++) begin
         press_only(bounce_pat[i] != 0 ? K_9 : -1);
         repeat (FRAME / 2) @(posedge clk);
         #1;
      end
      chk("bounce_no_key_down", key_down, 1'b0);
      press_only(K_9);
      exp_q.push_back(4'h9);
      hold_frames(4);
      chk("strobe_9_seen", exp_q.size(), 0);
      chk("key_down_9", key_down, 1'b1);
      press_only(-1);
      hold_frames(4);

      // '2' and 'D' together: column 1 scans first
      pressed = '0;
      pressed[K_2] = 1'b1;
      pressed[K_D] = 1'b1;
      exp_q.push_back(4'h2);
      hold_frames(4);
      chk("strobe_2_seen", exp_q.size(), 0);
      // Direct switch to 'E'
      press_only(K_E);
      exp_q.push_back(4'hE);
      hold_frames(4);
      chk("strobe_E_seen", exp_q.size(), 0);
      chk("instruments_E_held", instruments, 4'hE);
      press_only(-1);
      hold_frames(4);

      // Reset two frames into debouncing 'A'
      press_only(K_A);
      hold_frames(2);
      chk("pre_reset_instruments", instruments, 4'hE);
      #3;
      reset = 1'b0;
      #1;
      chk("midreset_col", col, 4'b0111);
      chk("midreset_instruments", instruments, 4'h0);
      chk("midreset_new_instrument", new_instrument, 1'b0);
      chk("midreset_key_down", key_down, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      min_strobe_cyc = cyc + 3 * FRAME;
      exp_q.push_back(4'hA);
      hold_frames(4);
      chk("strobe_A_seen", exp_q.size(), 0);
      chk("instruments_A", instruments, 4'hA);

      press_only(-1);
      hold_frames(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
